// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared defaults and types for the register-file write-port arbiter.
package regfile_wr_arbiter_pkg;

   localparam int unsigned DW_DEF       = 32;
   localparam int unsigned AW_DEF       = 5;
   localparam int unsigned DEPTH_DEF    = 2;
   localparam int unsigned MAX_WAIT_DEF = 4;
   localparam int unsigned REG_ZERO     = 0;

   typedef enum logic [1:0] {
      ISSUE_NONE,
      ISSUE_WB,
      ISSUE_MD
   } issue_sel_e;

endpackage

// File: rtl/regfile_wr_arbiter_sync_fifo.sv
// In-order FIFO for MDU results; exposes per-slot valid bits and addresses
// so the arbiter can build the pending-write mask.
module sync_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 37,
   parameter int unsigned AW    = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  logic [WIDTH-1:0]          push_data,
   input  logic                      pop,
   output logic [WIDTH-1:0]          head_data,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    count,
   output logic [DEPTH-1:0]          valid_vec,
   output logic [DEPTH*AW-1:0]       addr_vec
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_data;
   end

   // Clear-on-pop precedes set-on-push so a same-slot pair leaves the slot valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         valid_vec <= '0;
      end else begin
         if (pop) begin
            valid_vec[rd_ptr] <= 1'b0;
            rd_ptr            <= rd_ptr + PW'(1);
         end
         if (push) begin
            valid_vec[wr_ptr] <= 1'b1;
            wr_ptr            <= wr_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      addr_vec = '0;
      for (int unsigned i = 0; i < DEPTH; i++)
         addr_vec[i*AW +: AW] = mem[i][WIDTH-1 -: AW];
   end

   assign head_data = mem[rd_ptr];
   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between the WB stage and queued MDU
// results; WB has priority, bounded by a starvation limit and a WAW guard.
module regfile_wr_arbiter
   import regfile_wr_arbiter_pkg::*;
#(
   parameter int unsigned DW       = DW_DEF,
   parameter int unsigned AW       = AW_DEF,
   parameter int unsigned DEPTH    = DEPTH_DEF,
   parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wb_valid,
   input  logic [AW-1:0]           wb_addr,
   input  logic [DW-1:0]           wb_data,
   output logic                    wb_ready,
   input  logic                    md_valid,
   input  logic [AW-1:0]           md_addr,
   input  logic [DW-1:0]           md_data,
   output logic                    md_ready,
   output logic                    rf_we,
   output logic [AW-1:0]           rf_waddr,
   output logic [DW-1:0]           rf_wdata,
   output logic [2**AW-1:0]        pend_mask,
   output logic [$clog2(DEPTH):0]  md_fifo_cnt
);

   localparam int unsigned SW = $clog2(MAX_WAIT + 1);
   localparam int unsigned EW = AW + DW;

   logic [EW-1:0]       head;
   logic                fifo_full;
   logic                fifo_empty;
   logic [DEPTH-1:0]    slot_vld;
   logic [DEPTH*AW-1:0] slot_addr;
   logic                md_push;
   logic                md_pop;
   logic                force_md;
   logic                wb_hit;
   logic [SW-1:0]       starve_cnt;
   issue_sel_e          sel;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW),
      .AW    (AW)
   ) u_md_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (md_push),
      .push_data ({md_addr, md_data}),
      .pop       (md_pop),
      .head_data (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (md_fifo_cnt),
      .valid_vec (slot_vld),
      .addr_vec  (slot_addr)
   );

   assign md_ready = !fifo_full;
   assign md_push  = md_valid && md_ready && (md_addr != AW'(REG_ZERO));

   always_comb begin
      pend_mask = '0;
      for (int unsigned i = 0; i < DEPTH; i++)
         if (slot_vld[i])
            pend_mask[slot_addr[i*AW +: AW]] = 1'b1;
   end

   // wb_ready is kept independent of wb_valid to avoid a combinational loop
   // through the pipeline's stall logic.
   assign force_md = (starve_cnt == SW'(MAX_WAIT));
   assign wb_hit   = (wb_addr != AW'(REG_ZERO)) && pend_mask[wb_addr];
   assign wb_ready = !force_md && !wb_hit;

   always_comb begin
      sel = ISSUE_NONE;
      if (wb_valid && wb_ready && (wb_addr != AW'(REG_ZERO)))
         sel = ISSUE_WB;
      else if (!fifo_empty)
         sel = ISSUE_MD;
   end

   assign md_pop = (sel == ISSUE_MD);

   always_ff @(posedge clk) begin
      if (reset) begin
         rf_we      <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
         starve_cnt <= '0;
      end else begin
         rf_we <= (sel != ISSUE_NONE);
         case (sel)
            ISSUE_WB: begin
               rf_waddr <= wb_addr;
               rf_wdata <= wb_data;
            end
            ISSUE_MD: begin
               rf_waddr <= head[EW-1 -: AW];
               rf_wdata <= head[DW-1:0];
            end
            default: ;
         endcase
         if (fifo_empty || md_pop)
            starve_cnt <= '0;
         else if (!force_md)
            starve_cnt <= starve_cnt + SW'(1);
      end
   end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Vector table drives the arbiter; a queue-based reference model predicts
// every register-file write and the pending-write state.
module tb_regfile_wr_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned MAX_WAIT = 4;

   logic          clk;
   logic          reset;
   logic          wb_valid;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic          wb_ready;
   logic          md_valid;
   logic [AW-1:0] md_addr;
   logic [DW-1:0] md_data;
   logic          md_ready;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic [31:0]   pend_mask;
   logic [1:0]    md_fifo_cnt;

   regfile_wr_arbiter #(
      .DW       (DW),
      .AW       (AW),
      .DEPTH    (DEPTH),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .wb_ready    (wb_ready),
      .md_valid    (md_valid),
      .md_addr     (md_addr),
      .md_data     (md_data),
      .md_ready    (md_ready),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .pend_mask   (pend_mask),
      .md_fifo_cnt (md_fifo_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          rst;
      logic          wv;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic          mv;
      logic [AW-1:0] ma;
      logic [DW-1:0] md;
      logic          chk;
      logic          ewr;
      logic          emr;
      logic [1:0]    ecnt;
   } vec_t;

   typedef struct {
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   vec_t        tbl[$];
   wr_t         scb[$];
   ent_t        mq[$];
   int          total = 0;
   int          bad = 0;
   int          m_starve = 0;
   logic [AW-1:0] m_last_a = '0;
   logic [DW-1:0] m_last_d = '0;
   logic [DW-1:0] shadow [32];

   function automatic vec_t mk(input logic rst, input logic wv, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input logic mv, input logic [AW-1:0] ma,
                               input logic [DW-1:0] md, input logic chk, input logic ewr,
                               input logic emr, input logic [1:0] ecnt);
      vec_t v;
      v.rst = rst; v.wv = wv; v.wa = wa; v.wd = wd; v.mv = mv; v.ma = ma; v.md = md;
      v.chk = chk; v.ewr = ewr; v.emr = emr; v.ecnt = ecnt;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input vec_t v);
      logic [31:0] m_mask;
      logic        m_wr, m_mr, iss_wb, iss_md, psh;
      wr_t         e;
      ent_t        h;
      reset    = v.rst;
      wb_valid = v.wv;
      wb_addr  = v.wa;
      wb_data  = v.wd;
      md_valid = v.mv;
      md_addr  = v.ma;
      md_data  = v.md;
      #3;
      m_mask = '0;
      foreach (mq[i]) m_mask[mq[i].a] = 1'b1;
      m_wr = !(m_starve == MAX_WAIT) && !((v.wa != 0) && m_mask[v.wa]);
      m_mr = (mq.size() < DEPTH);
      check("pend_mask", pend_mask, m_mask);
      if (v.chk) begin
         check("wb_ready", {31'd0, wb_ready}, {31'd0, v.ewr});
         check("md_ready", {31'd0, md_ready}, {31'd0, v.emr});
         check("md_fifo_cnt", {30'd0, md_fifo_cnt}, {30'd0, v.ecnt});
      end else begin
         check("wb_ready_model", {31'd0, wb_ready}, {31'd0, m_wr});
      end
      iss_wb = v.wv && m_wr && (v.wa != 0);
      iss_md = !iss_wb && (mq.size() > 0);
      psh    = v.mv && m_mr && (v.ma != 0);
      if (v.rst) begin
         mq.delete();
         m_starve = 0;
         m_last_a = '0;
         m_last_d = '0;
         e.we = 1'b0;
      end else begin
         e.we = iss_wb || iss_md;
         if (mq.size() == 0 || iss_md) m_starve = 0;
         else if (m_starve < MAX_WAIT) m_starve++;
         if (iss_wb) begin
            m_last_a = v.wa;
            m_last_d = v.wd;
         end else if (iss_md) begin
            h = mq.pop_front();
            m_last_a = h.a;
            m_last_d = h.d;
         end
         if (psh) begin
            h.a = v.ma;
            h.d = v.md;
            mq.push_back(h);
         end
      end
      e.a = m_last_a;
      e.d = m_last_d;
      scb.push_back(e);
      @(posedge clk);
      #1;
      if (scb.size() == 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
         e = scb.pop_front();
         check("rf_we", {31'd0, rf_we}, {31'd0, e.we});
         check("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.a});
         check("rf_wdata", rf_wdata, e.d);
         if (rf_we === 1'b1) shadow[rf_waddr] = rf_wdata;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      foreach (shadow[i]) shadow[i] = '0;
      reset = 1'b1;
      wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
      md_valid = 1'b0; md_addr = '0; md_data = '0;
      //              rst wv wa  wd            mv ma  md          chk wr mr cnt
      tbl.push_back(mk(1, 0, 0,  0,            0, 0,  0,          0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0,          1, 1, 1, 0));
      tbl.push_back(mk(0, 1, 3,  32'hDEADBEEF, 0, 0,  0,          1, 1, 1, 0));
      tbl.push_back(mk(0, 1, 0,  32'h1234,     0, 0,  0,          1, 1, 1, 0));
      tbl.push_back(mk(0, 1, 1,  32'h11,       1, 5,  32'hA5,     1, 1, 1, 0));
      tbl.push_back(mk(0, 1, 2,  32'h22,       1, 6,  32'hA6,     1, 1, 1, 1));
      tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0,          1, 1, 0, 2));
      tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0,          1, 1, 1, 1));
      tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0,          1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0,  0,            1, 7,  32'h77,     1, 1, 1, 0));
      tbl.push_back(mk(0, 1, 9,  32'h90,       0, 0,  0,          1, 1, 1, 1));
      tbl.push_back(mk(0, 1, 9,  32'h91,       0, 0,  0,          1, 1, 1, 1));
      tbl.push_back(mk(0, 1, 9,  32'h92,       0, 0,  0,          1, 1, 1, 1));
      tbl.push_back(mk(0, 1, 9,  32'h93,       0, 0,  0,          1, 1, 1, 1));
      tbl.push_back(mk(0, 1, 9,  32'h94,       0, 0,  0,          1, 0, 1, 1));
      tbl.push_back(mk(0, 1, 9,  32'h95,       0, 0,  0,          1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0,  0,            1, 8,  32'h88,     1, 1, 1, 0));
      tbl.push_back(mk(0, 1, 8,  32'h8B,       0, 0,  0,          1, 0, 1, 1));
      tbl.push_back(mk(0, 1, 8,  32'h8B,       0, 0,  0,          1, 1, 1, 0));
      tbl.push_back(mk(0, 1, 4,  32'h44,       1, 10, 32'h100,    1, 1, 1, 0));
      tbl.push_back(mk(0, 1, 0,  32'h0,        1, 11, 32'h101,    1, 1, 1, 1));
      tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0,          1, 1, 1, 1));
      tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0,          1, 1, 1, 0));
      tbl.push_back(mk(0, 1, 12, 32'hC1,       1, 12, 32'hC0,     1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0,          1, 1, 1, 1));
      tbl.push_back(mk(0, 0, 0,  0,            1, 0,  32'hFF,     1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0,          1, 1, 1, 0));
      tbl.push_back(mk(0, 1, 1,  32'h1,        1, 13, 32'hD0,     1, 1, 1, 0));
      tbl.push_back(mk(0, 1, 2,  32'h2,        1, 14, 32'hE0,     1, 1, 1, 1));
      tbl.push_back(mk(1, 0, 0,  0,            0, 0,  0,          1, 1, 0, 2));
      tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0,          1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0,  0,            0, 0,  0,          1, 1, 1, 0));

      @(posedge clk);
      #1;
      foreach (tbl[i]) step(tbl[i]);

      // Both register 8 and 12 must end with the later writer's data.
      check("r8_final", shadow[8], 32'h8B);
      check("r12_final", shadow[12], 32'hC0);
      check("r13_flushed", shadow[13], 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
